// File: rtl/pic_pkg.sv
// -----------------------------------------------------------------------------
// pic_pkg
// Shared definitions for the 8259A interrupt acknowledge sequencer:
//   - ack_state_e : acknowledge sequence states
//   - OCW2 EOI command codes (OCW2[7:5])
//   - SPURIOUS_IDX : vector index returned for a vanished request
//   - scan_t : result of the rotating first-set-bit search
//   - idx_mask() : 3-bit index to one-hot 8-bit mask
// -----------------------------------------------------------------------------
package pic_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WAIT1 = 3'd1,
      ACK1  = 3'd2,
      WAIT2 = 3'd3,
      ACK2  = 3'd4
   } ack_state_e;

   localparam logic [2:0] NS_EOI     = 3'b001;
   localparam logic [2:0] SP_EOI     = 3'b011;
   localparam logic [2:0] ROT_NS_EOI = 3'b101;
   localparam logic [2:0] ROT_SP_EOI = 3'b111;

   localparam logic [2:0] SPURIOUS_IDX = 3'd7;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } scan_t;

   function automatic logic [7:0] idx_mask(input logic [2:0] idx);
      return 8'h01 << idx;
   endfunction

endpackage

// File: rtl/inta_sync.sv
// -----------------------------------------------------------------------------
// inta_sync
// Synchronises the asynchronous active-low INTA_n pin and turns its edges
// into single-cycle event pulses. The last synchroniser stage is compared
// with a history flop; a difference is a fall or rise event.
// Ports:
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset (all flops load 1 = idle pin)
//   inta_n    in  raw CPU acknowledge pin
//   inta_fall out one-cycle pulse, synchronised INTA_n went 1 -> 0
//   inta_rise out one-cycle pulse, synchronised INTA_n went 0 -> 1
// -----------------------------------------------------------------------------
module inta_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inta_n,
   output logic inta_fall,
   output logic inta_rise
);

   // Fewer than two stages is not a safe synchroniser, so clamp upward.
   localparam int STAGES = (SYNC_STAGES < 32'sd2) ? 32'sd2 : SYNC_STAGES;

   logic [STAGES-1:0] sync_r;
   logic              hist_r;

   // Synchroniser chain plus history flop; reset to the idle-high pin level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= {STAGES{1'b1}};
         hist_r <= 1'b1;
      end else begin
         sync_r <= {sync_r[STAGES-2:0], inta_n};
         hist_r <= sync_r[STAGES-1];
      end
   end

   assign inta_fall = hist_r & ~sync_r[STAGES-1];
   assign inta_rise = ~hist_r & sync_r[STAGES-1];

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// -----------------------------------------------------------------------------
// interrupt_ack_sequencer
// Downstream of the priority resolver in the 8259A. Raises INT to the CPU,
// runs the two-pulse 8086-mode INTA_n cycle, owns the In-Service Register and
// executes EOI commands from OCW2.
// Ports:
//   clk                      in   system clock
//   rst_n                    in   asynchronous active-low reset
//   INT_request              in   level request from the resolver
//   serviced_interrupt_index in   winning IR index
//   zeroLevelPriorityBit     in   highest-priority IR (start of non-specific EOI scan)
//   INTA_n                   in   CPU acknowledge, asynchronous, active-low
//   ICW2_vector              in   T7..T3 of the vector byte
//   AEOI                     in   automatic EOI mode
//   OCW2 / OCW2_write        in   OCW2 byte and its one-cycle write strobe
//   INT                      out  interrupt to the CPU
//   ISR_reg                  out  In-Service Register
//   resetedISR_index/_valid  out  index of the ISR bit just cleared + pulse
//   freezing                 out  freezes IRR/resolver during INTA sequence
//   INT_requestAck           out  toggles once per completed sequence
//   data_out / data_oe       out  vector byte and data bus enable
// -----------------------------------------------------------------------------
module interrupt_ack_sequencer
   import pic_pkg::*;
#(
   parameter int         SYNC_STAGES    = 2,
   parameter logic [2:0] SPURIOUS_INDEX = SPURIOUS_IDX
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       INT_request,
   input  logic [2:0] serviced_interrupt_index,
   input  logic [2:0] zeroLevelPriorityBit,
   input  logic       INTA_n,
   input  logic [4:0] ICW2_vector,
   input  logic       AEOI,
   input  logic [7:0] OCW2,
   input  logic       OCW2_write,
   output logic       INT,
   output logic [7:0] ISR_reg,
   output logic [2:0] resetedISR_index,
   output logic       resetedISR_valid,
   output logic       freezing,
   output logic       INT_requestAck,
   output logic [7:0] data_out,
   output logic       data_oe
);

   ack_state_e state_r;
   logic [2:0] idx_r;
   logic       spurious_r;

   logic       inta_fall_s;
   logic       inta_rise_s;

   scan_t      scan_s;
   logic       eoi_hit_s;
   logic [2:0] eoi_idx_s;
   logic [7:0] eoi_clr_s;
   logic       aeoi_hit_s;
   logic [7:0] aeoi_clr_s;
   logic [7:0] set_mask_s;
   logic [7:0] isr_next_s;
   logic       clr_valid_s;
   logic [2:0] clr_idx_s;
   logic       ocw2_unused_s;

   // First set bit of vec, scanning upward from start and wrapping modulo 8.
   // Walks from the far end back toward start so the nearest hit is written last.
   function automatic scan_t first_set_rot(input logic [7:0] vec, input logic [2:0] start);
      scan_t      res;
      logic [2:0] pos;
      res.found = 1'b0;
      res.idx   = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         pos = start + 3'(k);
         if (vec[pos]) begin
            res.found = 1'b1;
            res.idx   = pos;
         end
      end
      return res;
   endfunction

   inta_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_inta_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .inta_n    (INTA_n),
      .inta_fall (inta_fall_s),
      .inta_rise (inta_rise_s)
   );

   // OCW2 bits 4:3 only select the OCW2 register at the bus decoder.
   assign ocw2_unused_s = ^OCW2[4:3];

   assign scan_s = first_set_rot(ISR_reg, zeroLevelPriorityBit);

   // EOI command decode: which ISR bit (if any) an OCW2 write clears this cycle.
   always_comb begin
      eoi_hit_s = 1'b0;
      eoi_idx_s = 3'd0;
      if (OCW2_write) begin
         case (OCW2[7:5])
            NS_EOI, ROT_NS_EOI: begin
               eoi_hit_s = scan_s.found;
               eoi_idx_s = scan_s.idx;
            end
            SP_EOI, ROT_SP_EOI: begin
               // Only a bit that is actually set counts as cleared.
               eoi_hit_s = ISR_reg[OCW2[2:0]];
               eoi_idx_s = OCW2[2:0];
            end
            default: begin
               eoi_hit_s = 1'b0;
               eoi_idx_s = 3'd0;
            end
         endcase
      end else begin
         eoi_hit_s = 1'b0;
         eoi_idx_s = 3'd0;
      end
      eoi_clr_s = eoi_hit_s ? idx_mask(eoi_idx_s) : 8'h00;
   end

   // Sequencer-driven ISR set (first INTA) and automatic-EOI clear (second INTA).
   always_comb begin
      set_mask_s = 8'h00;
      aeoi_hit_s = 1'b0;
      if ((state_r == WAIT1) && inta_fall_s && INT_request) begin
         set_mask_s = idx_mask(serviced_interrupt_index);
      end else begin
         set_mask_s = 8'h00;
      end
      if ((state_r == ACK2) && inta_rise_s && AEOI && !spurious_r) begin
         aeoi_hit_s = ISR_reg[idx_r];
      end else begin
         aeoi_hit_s = 1'b0;
      end
      aeoi_clr_s = aeoi_hit_s ? idx_mask(idx_r) : 8'h00;
   end

   // Next ISR value and the cleared-bit report; a set beats a clear on the same
   // bit, and the AEOI clear owns the report when both clears happen together.
   always_comb begin
      isr_next_s  = (ISR_reg & ~(eoi_clr_s | aeoi_clr_s)) | set_mask_s;
      clr_valid_s = 1'b0;
      clr_idx_s   = 3'd0;
      if (aeoi_hit_s) begin
         clr_valid_s = 1'b1;
         clr_idx_s   = idx_r;
      end else if (eoi_hit_s) begin
         clr_valid_s = 1'b1;
         clr_idx_s   = eoi_idx_s;
      end else begin
         clr_valid_s = 1'b0;
         clr_idx_s   = 3'd0;
      end
   end

   // Acknowledge state machine with registered outputs and ISR update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r          <= IDLE;
         idx_r            <= 3'd0;
         spurious_r       <= 1'b0;
         INT              <= 1'b0;
         ISR_reg          <= 8'h00;
         resetedISR_index <= 3'd0;
         resetedISR_valid <= 1'b0;
         freezing         <= 1'b0;
         INT_requestAck   <= 1'b0;
         data_out         <= 8'h00;
         data_oe          <= 1'b0;
      end else begin
         ISR_reg          <= isr_next_s;
         resetedISR_valid <= clr_valid_s;
         if (clr_valid_s) begin
            resetedISR_index <= clr_idx_s;
         end
         case (state_r)
            IDLE: begin
               if (INT_request) begin
                  INT     <= 1'b1;
                  state_r <= WAIT1;
               end
            end
            WAIT1: begin
               if (inta_fall_s) begin
                  freezing <= 1'b1;
                  INT      <= 1'b0;
                  if (INT_request) begin
                     idx_r      <= serviced_interrupt_index;
                     spurious_r <= 1'b0;
                  end else begin
                     // Request vanished before the first INTA: spurious vector.
                     idx_r      <= SPURIOUS_INDEX;
                     spurious_r <= 1'b1;
                  end
                  state_r <= ACK1;
               end
            end
            ACK1: begin
               if (inta_rise_s) begin
                  state_r <= WAIT2;
               end
            end
            WAIT2: begin
               if (inta_fall_s) begin
                  data_out <= {ICW2_vector, idx_r};
                  data_oe  <= 1'b1;
                  state_r  <= ACK2;
               end
            end
            ACK2: begin
               if (inta_rise_s) begin
                  data_oe        <= 1'b0;
                  freezing       <= 1'b0;
                  INT_requestAck <= ~INT_requestAck;
                  state_r        <= IDLE;
               end
            end
            default: begin
               state_r  <= IDLE;
               INT      <= 1'b0;
               freezing <= 1'b0;
               data_oe  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// -----------------------------------------------------------------------------
// tb_interrupt_ack_sequencer
// Directed scenarios followed by randomized acknowledge sequences and EOI
// commands, checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_interrupt_ack_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       INT_request;
   logic [2:0] serviced_interrupt_index;
   logic [2:0] zeroLevelPriorityBit;
   logic       INTA_n;
   logic [4:0] ICW2_vector;
   logic       AEOI;
   logic [7:0] OCW2;
   logic       OCW2_write;
   logic       INT;
   logic [7:0] ISR_reg;
   logic [2:0] resetedISR_index;
   logic       resetedISR_valid;
   logic       freezing;
   logic       INT_requestAck;
   logic [7:0] data_out;
   logic       data_oe;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [7:0] m_isr;
   logic       m_ack;
   logic       m_int;

   interrupt_ack_sequencer dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .INT_request              (INT_request),
      .serviced_interrupt_index (serviced_interrupt_index),
      .zeroLevelPriorityBit     (zeroLevelPriorityBit),
      .INTA_n                   (INTA_n),
      .ICW2_vector              (ICW2_vector),
      .AEOI                     (AEOI),
      .OCW2                     (OCW2),
      .OCW2_write               (OCW2_write),
      .INT                      (INT),
      .ISR_reg                  (ISR_reg),
      .resetedISR_index         (resetedISR_index),
      .resetedISR_valid         (resetedISR_valid),
      .freezing                 (freezing),
      .INT_requestAck           (INT_requestAck),
      .data_out                 (data_out),
      .data_oe                  (data_oe)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // EOI rule: which set ISR bit an OCW2 byte clears, if any.
   task automatic model_eoi(input logic [7:0] isr, input logic [7:0] b, input logic [2:0] zlp,
                            output bit hit, output int pos);
      hit = 1'b0;
      pos = 0;
      case (b[7:5])
         3'b001, 3'b101: begin
            for (int k = 0; k < 8; k++) begin
               int p;
               p = (int'(zlp) + k) % 8;
               if (!hit && isr[p]) begin
                  hit = 1'b1;
                  pos = p;
               end
            end
         end
         3'b011, 3'b111: begin
            if (isr[b[2:0]]) begin
               hit = 1'b1;
               pos = int'(b[2:0]);
            end
         end
         default: hit = 1'b0;
      endcase
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_int"}, 32'(INT), 32'd0);
      check_eq({tag, "_isr"}, 32'(ISR_reg), 32'd0);
      check_eq({tag, "_ridx"}, 32'(resetedISR_index), 32'd0);
      check_eq({tag, "_rval"}, 32'(resetedISR_valid), 32'd0);
      check_eq({tag, "_frz"}, 32'(freezing), 32'd0);
      check_eq({tag, "_ack"}, 32'(INT_requestAck), 32'd0);
      check_eq({tag, "_dout"}, 32'(data_out), 32'd0);
      check_eq({tag, "_doe"}, 32'(data_oe), 32'd0);
   endtask

   // One EOI command write, checked one cycle later and again the cycle after.
   task automatic eoi_op(input logic [7:0] b, input logic [2:0] zlp);
      bit hit;
      int pos;
      OCW2 = b;
      zeroLevelPriorityBit = zlp;
      OCW2_write = 1'b1;
      model_eoi(m_isr, b, zlp, hit, pos);
      step(1);
      OCW2_write = 1'b0;
      if (hit) m_isr[pos] = 1'b0;
      check_eq("eoi_valid", 32'(resetedISR_valid), 32'(hit));
      if (hit) check_eq("eoi_index", 32'(resetedISR_index), 32'(pos));
      check_eq("eoi_isr", 32'(ISR_reg), 32'(m_isr));
      check_eq("eoi_int", 32'(INT), 32'(m_int));
      step(1);
      check_eq("eoi_pulse_end", 32'(resetedISR_valid), 32'd0);
      check_eq("eoi_isr2", 32'(ISR_reg), 32'(m_isr));
   endtask

   // Full request + two-pulse INTA sequence. Each INTA edge is expected to
   // act three clock edges after the first edge that samples it.
   task automatic run_seq(input logic [2:0] idx, input logic [4:0] vec, input logic aeoi,
                          input bit spur, input bit keep_req, input bit do_eoi,
                          input logic [7:0] eoi_byte, input bit abort);
      bit         hit;
      int         pos;
      bit         exp_valid;
      logic [7:0] clr;
      logic [2:0] vidx;
      INT_request = 1'b1;
      serviced_interrupt_index = idx;
      ICW2_vector = vec;
      AEOI = aeoi;
      step(1);
      check_eq("int_rise", 32'(INT), 32'd1);
      check_eq("frz_idle", 32'(freezing), 32'd0);
      m_int = 1'b1;
      if (spur) INT_request = 1'b0;
      step($urandom_range(0, 2));
      INTA_n = 1'b0;
      step(2);
      check_eq("int_hold", 32'(INT), 32'd1);
      check_eq("frz_lat", 32'(freezing), 32'd0);
      hit = 1'b0;
      pos = 0;
      if (do_eoi) begin
         OCW2 = eoi_byte;
         OCW2_write = 1'b1;
         model_eoi(m_isr, eoi_byte, zeroLevelPriorityBit, hit, pos);
      end
      step(1);
      OCW2_write = 1'b0;
      clr = hit ? (8'h01 << pos) : 8'h00;
      m_isr = (m_isr & ~clr) | (spur ? 8'h00 : (8'h01 << idx));
      m_int = 1'b0;
      check_eq("inta1_int", 32'(INT), 32'd0);
      check_eq("inta1_frz", 32'(freezing), 32'd1);
      check_eq("inta1_isr", 32'(ISR_reg), 32'(m_isr));
      check_eq("inta1_doe", 32'(data_oe), 32'd0);
      check_eq("inta1_rval", 32'(resetedISR_valid), 32'(hit));
      if (hit) check_eq("inta1_ridx", 32'(resetedISR_index), 32'(pos));
      if (!keep_req) INT_request = 1'b0;
      if (abort) begin
         #2 rst_n = 1'b0;
         #1 check_all_zero("async_rst");
         m_isr = 8'h00;
         m_ack = 1'b0;
         m_int = 1'b0;
         @(negedge clk);
         INTA_n = 1'b1;
         INT_request = 1'b0;
         rst_n = 1'b1;
         step(1);
         check_all_zero("post_rst");
      end else begin
         step($urandom_range(0, 2));
         INTA_n = 1'b1;
         step(2);
         check_eq("ack1_frz", 32'(freezing), 32'd1);
         step(1);
         check_eq("ack1_doe", 32'(data_oe), 32'd0);
         step($urandom_range(1, 3));
         INTA_n = 1'b0;
         step(2);
         check_eq("oe_lat", 32'(data_oe), 32'd0);
         step(1);
         vidx = spur ? 3'd7 : idx;
         check_eq("inta2_doe", 32'(data_oe), 32'd1);
         check_eq("inta2_dout", 32'(data_out), 32'({vec, vidx}));
         check_eq("inta2_frz", 32'(freezing), 32'd1);
         step($urandom_range(0, 2));
         INTA_n = 1'b1;
         step(2);
         check_eq("oe_hold", 32'(data_oe), 32'd1);
         step(1);
         exp_valid = aeoi && !spur && m_isr[idx];
         if (exp_valid) m_isr[idx] = 1'b0;
         m_ack = ~m_ack;
         check_eq("end_doe", 32'(data_oe), 32'd0);
         check_eq("end_frz", 32'(freezing), 32'd0);
         check_eq("end_ack", 32'(INT_requestAck), 32'(m_ack));
         check_eq("end_isr", 32'(ISR_reg), 32'(m_isr));
         check_eq("end_rval", 32'(resetedISR_valid), 32'(exp_valid));
         if (exp_valid) check_eq("end_ridx", 32'(resetedISR_index), 32'(idx));
         check_eq("end_int", 32'(INT), 32'd0);
         step(1);
         check_eq("end_pulse", 32'(resetedISR_valid), 32'd0);
         if (keep_req) begin
            check_eq("int_reassert", 32'(INT), 32'd1);
            m_int = 1'b1;
         end else begin
            check_eq("int_idle", 32'(INT), 32'd0);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      INT_request = 1'b0;
      serviced_interrupt_index = 3'd0;
      zeroLevelPriorityBit = 3'd0;
      INTA_n = 1'b1;
      ICW2_vector = 5'd0;
      AEOI = 1'b0;
      OCW2 = 8'h00;
      OCW2_write = 1'b0;
      m_isr = 8'h00;
      m_ack = 1'b0;
      m_int = 1'b0;
      step(2);
      check_all_zero("reset");
      rst_n = 1'b1;
      step(1);

      // Basic sequence, no AEOI: vector 0x43, ISR 0x08, ack 0->1
      run_seq(3'd3, 5'b01000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      check_eq("tp1_isr", 32'(ISR_reg), 32'h08);
      check_eq("tp1_ack", 32'(INT_requestAck), 32'd1);
      // Same with AEOI: ISR back to 0, pulse with index 3
      run_seq(3'd3, 5'b01000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      check_eq("tp2_isr", 32'(ISR_reg), 32'h00);
      // Spurious
      run_seq(3'd4, 5'b01000, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      check_eq("tp3_isr", 32'(ISR_reg), 32'h00);
      // Build ISR=0x24, non-specific EOI from level 3, then specific EOI on a clear bit
      run_seq(3'd2, 5'b10101, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      run_seq(3'd5, 5'b10101, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      check_eq("tp4_isr", 32'(ISR_reg), 32'h24);
      eoi_op(8'h20, 3'd3);
      check_eq("tp4_isr_after", 32'(ISR_reg), 32'h04);
      check_eq("tp4_ridx", 32'(resetedISR_index), 32'd5);
      eoi_op(8'h65, 3'd3);
      // Specific EOI on bit 2 in the same cycle INTA1 sets bit 2
      run_seq(3'd2, 5'b00011, 1'b0, 1'b0, 1'b0, 1'b1, 8'h62, 1'b0);
      check_eq("tp6_isr2", 32'(ISR_reg[2]), 32'd1);
      // INT re-asserts immediately when the request is still present
      run_seq(3'd1, 5'b11100, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      run_seq(3'd6, 5'b11100, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      // Reset during ACK1, then INTA pulses with no request
      run_seq(3'd0, 5'b01010, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      for (int p = 0; p < 2; p++) begin
         INTA_n = 1'b0;
         for (int c = 0; c < 4; c++) begin
            step(1);
            check_eq("norq_doe_lo", 32'(data_oe), 32'd0);
            check_eq("norq_int_lo", 32'(INT), 32'd0);
         end
         INTA_n = 1'b1;
         for (int c = 0; c < 4; c++) begin
            step(1);
            check_eq("norq_doe_hi", 32'(data_oe), 32'd0);
            check_eq("norq_frz_hi", 32'(freezing), 32'd0);
         end
      end

      // Randomized mix of sequences and EOI commands
      for (int it = 0; it < 200; it++) begin
         zeroLevelPriorityBit = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) < 6) begin
            bit sp;
            bit kr;
            sp = ($urandom_range(0, 5) == 0);
            kr = !sp && ($urandom_range(0, 3) == 0);
            run_seq(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)), sp, kr,
                    ($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255)), 1'b0);
         end else begin
            eoi_op(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/interrupt_ack_sequencer.md
Name: interrupt_ack_sequencer

Overview:
- Sits directly downstream of the PriorityResolver in the 8259A PIC.
- Consumes INT_request and serviced_interrupt_index, drives INT to the CPU, and runs the two-pulse INTA_n cycle in 8086 mode.
- Owns the In-Service Register and processes EOI commands.
- Feeds ISR_reg, resetedISR_index, freezing and INT_requestAck back to the resolver.

Parameters:
- SYNC_STAGES, 2, number of flops synchronising the asynchronous INTA_n pin (minimum 2).
- SPURIOUS_INDEX, 3'd7, vector index returned when the request vanishes before the first INTA.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- INT_request  in  1  level request from the resolver.
- serviced_interrupt_index  in  3  winning IR index from the resolver.
- zeroLevelPriorityBit  in  3  current highest-priority IR index, used for non-specific EOI.
- INTA_n  in  1  CPU interrupt acknowledge, asynchronous, active-low.
- ICW2_vector  in  5  T7..T3 of the vector byte.
- AEOI  in  1  automatic-EOI mode from ICW4.
- OCW2  in  8  OCW2 byte.
- OCW2_write  in  1  one-cycle strobe; OCW2 is valid in that cycle.
- INT  out  1  interrupt to the CPU.
- ISR_reg  out  8  In-Service Register.
- resetedISR_index  out  3  index of the ISR bit just cleared.
- resetedISR_valid  out  1  one-cycle pulse qualifying resetedISR_index.
- freezing  out  1  freezes IRR/resolver during the INTA sequence.
- INT_requestAck  out  1  toggles once per completed acknowledge sequence.
- data_out  out  8  vector byte.
- data_oe  out  1  data bus output enable.

Behaviour:
- Reset: every output is 0 (INT, ISR_reg, resetedISR_*, freezing, INT_requestAck, data_out, data_oe). The synchroniser loads 1s. State is IDLE. Reset asserted mid-sequence aborts it immediately with no ack toggle.
- INTA_n passes through SYNC_STAGES flops plus one history flop. A fall or rise event fires when the last sync stage differs from the history flop. Every action below registers on the clock edge after its event. For SYNC_STAGES=2, an output changes 3 clk edges after the first edge that samples INTA_n low or high.
- IDLE: INT_request=1 -> INT<=1, go to WAIT1. INTA events are ignored here; data_oe stays 0.
- WAIT1, on INTA fall:
  - freezing<=1 and INT<=0.
  - If INT_request=1, latch idx<=serviced_interrupt_index and set ISR_reg[idx].
  - Otherwise (spurious), idx<=SPURIOUS_INDEX and leave ISR unchanged.
  - Go to ACK1.
- ACK1: data_oe stays 0. On INTA rise, go to WAIT2.
- WAIT2: on INTA fall, data_out<={ICW2_vector, idx} and data_oe<=1; go to ACK2.
- ACK2, on INTA rise:
  - data_oe<=0, freezing<=0, INT_requestAck<=~INT_requestAck.
  - If AEOI=1 and the sequence was not spurious, clear ISR_reg[idx], pulse resetedISR_valid, and set resetedISR_index<=idx.
  - Go to IDLE.
- After returning to IDLE, INT can re-assert on the very next cycle if INT_request is still 1.
- EOI on OCW2_write, decoded from OCW2[7:5]:
  - 001 or 101 (non-specific): clear the first set ISR bit, scanning from zeroLevelPriorityBit upward modulo 8.
  - 011 or 111 (specific): clear bit OCW2[2:0].
  - Any other code leaves the ISR unchanged.
- resetedISR_valid pulses for exactly one cycle, only when a set bit was actually cleared. An EOI on an empty ISR, or a specific EOI on a clear bit, produces no pulse.
- Simultaneous EOI clear and ISR set in one cycle: apply both. If they target the same bit, the set wins.
- Simultaneous EOI clear and AEOI clear in one cycle: the AEOI clear takes resetedISR_index/valid; the EOI clear still updates ISR_reg.
- An OCW2_write arriving mid-sequence is processed normally and does not disturb the state machine.

Decomposition:
- Package pic_pkg holds:
  - the state enum (IDLE, WAIT1, ACK1, WAIT2, ACK2);
  - OCW2 command codes (NS_EOI=3'b001, SP_EOI=3'b011, ROT_NS_EOI=3'b101, ROT_SP_EOI=3'b111);
  - the spurious index constant.
- One sub-module, inta_sync: N-flop synchroniser with a history flop, producing fall/rise pulses.
- The rotating first-set-bit search stays in the main module as a function.

Test Plan:
- Request with serviced_interrupt_index=3, ICW2_vector=5'b01000, AEOI=0, two INTA pulses -> INT rises then falls on INTA1; ISR_reg=8'h08; data_out=8'h43 with data_oe=1 only during INTA2; INT_requestAck toggles 0->1; freezing is high from INTA1 fall to INTA2 rise.
- Same stimulus with AEOI=1 -> ISR_reg returns to 0 at INTA2 rise; resetedISR_valid pulses once with resetedISR_index=3.
- INT_request drops after INT but before INTA1 -> data_out={ICW2_vector, 3'd7}; ISR_reg stays 0; ack still toggles.
- ISR_reg=8'h24, zeroLevelPriorityBit=3, OCW2=8'h20 write -> bit 5 cleared (ISR=8'h04), resetedISR_index=5. A second specific EOI OCW2=8'h65 -> no pulse.
- rst_n asserted during ACK1 -> all outputs 0 asynchronously; after release, INTA pulses with no request leave data_oe=0.
- Specific EOI for bit 2 in the same cycle the INTA1 action sets bit 2 -> ISR_reg[2]=1.
